// File: rtl/m_spi_slave_msg.sv
// SPI mode-0 slave: oversamples the SPI pins into the system clock domain, stores framed
// bytes in a message buffer with a registered read port, and shifts reply bytes out MSB first.
module m_spi_slave_msg #(
    parameter int DATA_WIDTH  = 8,
    parameter int MSG_DEPTH   = 64,
    parameter int SYNC_STAGES = 2
) (
    input  logic                         I_CLK,
    input  logic                         I_RESETN,
    input  logic                         SCLK_SLAVE,
    input  logic                         SS_N_SLAVE,
    input  logic                         MOSI_SLAVE,
    output logic                         MISO_SLAVE,
    input  logic [DATA_WIDTH-1:0]        I_TX_DATA,
    output logic                         O_TX_REQ,
    output logic [DATA_WIDTH-1:0]        O_RX_DATA,
    output logic                         O_RX_VALID,
    output logic [$clog2(MSG_DEPTH):0]   O_RX_COUNT,
    output logic                         O_OVERFLOW,
    output logic                         O_FRAME_DONE,
    input  logic [$clog2(MSG_DEPTH)-1:0] I_RADDR,
    output logic [DATA_WIDTH-1:0]        O_RDATA
);

    localparam int AW = $clog2(MSG_DEPTH);
    localparam int BW = $clog2(DATA_WIDTH);
    localparam logic [AW:0]   DEPTH_FULL = (AW+1)'(MSG_DEPTH);
    localparam logic [BW-1:0] LAST_BIT   = BW'(DATA_WIDTH - 1);

    typedef enum logic {IDLE, ACTIVE} state_t;

    state_t r_state;
    state_t w_stateNext;

    logic [SYNC_STAGES-1:0] r_sclkSync;
    logic [SYNC_STAGES-1:0] r_ssnSync;
    logic [SYNC_STAGES-1:0] r_mosiSync;
    logic [SYNC_STAGES-1:0] r_syncValid;
    logic                   r_sclkPrev;
    logic                   r_ssnPrev;
    logic                   r_armed;

    logic                   w_sclk;
    logic                   w_ssn;
    logic                   w_mosi;
    logic                   w_sclkRise;
    logic                   w_sclkFall;
    logic                   w_ssnRise;
    logic                   w_ssnFall;

    logic                   w_start;
    logic                   w_end;
    logic                   w_bitRise;
    logic                   w_bitFall;
    logic                   w_byteDone;
    logic                   w_memWrite;
    logic [DATA_WIDTH-1:0]  w_rxByte;

    logic [DATA_WIDTH-1:0]  r_txShift;
    logic [DATA_WIDTH-2:0]  r_rxShift;
    logic [BW-1:0]          r_bitCnt;
    logic [AW:0]            r_rxCount;
    logic [DATA_WIDTH-1:0]  r_rxData;
    logic                   r_rxValid;
    logic                   r_txReq;
    logic                   r_overflow;
    logic                   r_frameDone;
    logic [DATA_WIDTH-1:0]  r_mem [MSG_DEPTH];
    logic [DATA_WIDTH-1:0]  r_rdata;

    // A frame may only start after SS_N has been seen high through a fully refilled
    // synchroniser, so a reset released mid-frame cannot fake an SS_N fall.
    always_ff @(posedge I_CLK or negedge I_RESETN) begin
        if (!I_RESETN) begin
            r_sclkSync  <= '0;
            r_ssnSync   <= '1;
            r_mosiSync  <= '0;
            r_syncValid <= '0;
            r_sclkPrev  <= 1'b0;
            r_ssnPrev   <= 1'b1;
            r_armed     <= 1'b0;
        end else begin
            r_sclkSync  <= {r_sclkSync[SYNC_STAGES-2:0], SCLK_SLAVE};
            r_ssnSync   <= {r_ssnSync[SYNC_STAGES-2:0], SS_N_SLAVE};
            r_mosiSync  <= {r_mosiSync[SYNC_STAGES-2:0], MOSI_SLAVE};
            r_syncValid <= {r_syncValid[SYNC_STAGES-2:0], 1'b1};
            r_sclkPrev  <= w_sclk;
            r_ssnPrev   <= w_ssn;
            r_armed     <= r_armed | (r_syncValid[SYNC_STAGES-1] & w_ssn);
        end
    end

    assign w_sclk     = r_sclkSync[SYNC_STAGES-1];
    assign w_ssn      = r_ssnSync[SYNC_STAGES-1];
    assign w_mosi     = r_mosiSync[SYNC_STAGES-1];
    assign w_sclkRise = w_sclk & ~r_sclkPrev;
    assign w_sclkFall = ~w_sclk & r_sclkPrev;
    assign w_ssnRise  = w_ssn & ~r_ssnPrev;
    assign w_ssnFall  = r_armed & r_ssnPrev & ~w_ssn;

    always_ff @(posedge I_CLK or negedge I_RESETN) begin
        if (!I_RESETN) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_stateNext;
        end
    end

    always_comb begin
        w_stateNext = r_state;
        w_start     = 1'b0;
        w_end       = 1'b0;
        w_bitRise   = 1'b0;
        w_bitFall   = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_ssnFall) begin
                    w_stateNext = ACTIVE;
                    w_start     = 1'b1;
                end
            end
            ACTIVE: begin
                if (w_ssnRise) begin
                    w_stateNext = IDLE;
                    w_end       = 1'b1;
                end else begin
                    w_bitRise = w_sclkRise;
                    w_bitFall = w_sclkFall;
                end
            end
            default: w_stateNext = IDLE;
        endcase
    end

    assign w_rxByte   = {r_rxShift, w_mosi};
    assign w_byteDone = w_bitRise && (r_bitCnt == LAST_BIT);
    assign w_memWrite = w_byteDone && (r_rxCount < DEPTH_FULL);

    // The fall right after a byte load leaves the shifter alone so bit 7 of the new byte is sent.
    always_ff @(posedge I_CLK or negedge I_RESETN) begin
        if (!I_RESETN) begin
            r_txShift   <= '0;
            r_rxShift   <= '0;
            r_bitCnt    <= '0;
            r_rxCount   <= '0;
            r_rxData    <= '0;
            r_rxValid   <= 1'b0;
            r_txReq     <= 1'b0;
            r_overflow  <= 1'b0;
            r_frameDone <= 1'b0;
        end else begin
            r_rxValid   <= 1'b0;
            r_txReq     <= 1'b0;
            r_frameDone <= 1'b0;
            if (w_start) begin
                r_txShift  <= I_TX_DATA;
                r_txReq    <= 1'b1;
                r_bitCnt   <= '0;
                r_rxCount  <= '0;
                r_overflow <= 1'b0;
            end else if (w_end) begin
                r_bitCnt    <= '0;
                r_frameDone <= 1'b1;
            end else if (w_bitRise) begin
                r_rxShift <= w_rxByte[DATA_WIDTH-2:0];
                if (w_byteDone) begin
                    r_rxData  <= w_rxByte;
                    r_rxValid <= 1'b1;
                    r_txShift <= I_TX_DATA;
                    r_txReq   <= 1'b1;
                    r_bitCnt  <= '0;
                    if (w_memWrite) begin
                        r_rxCount <= r_rxCount + 1'b1;
                    end else begin
                        r_overflow <= 1'b1;
                    end
                end else begin
                    r_bitCnt <= r_bitCnt + 1'b1;
                end
            end else if (w_bitFall && (r_bitCnt != '0)) begin
                r_txShift <= {r_txShift[DATA_WIDTH-2:0], 1'b0};
            end
        end
    end

    always_ff @(posedge I_CLK or negedge I_RESETN) begin
        if (!I_RESETN) begin
            for (int i = 0; i < MSG_DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_rdata <= '0;
        end else begin
            if (w_memWrite) begin
                r_mem[r_rxCount[AW-1:0]] <= w_rxByte;
            end
            r_rdata <= r_mem[I_RADDR];
        end
    end

    assign MISO_SLAVE   = ~w_ssn & r_txShift[DATA_WIDTH-1];
    assign O_TX_REQ     = r_txReq;
    assign O_RX_DATA    = r_rxData;
    assign O_RX_VALID   = r_rxValid;
    assign O_RX_COUNT   = r_rxCount;
    assign O_OVERFLOW   = r_overflow;
    assign O_FRAME_DONE = r_frameDone;
    assign O_RDATA      = r_rdata;

endmodule

// File: tb/tb_m_spi_slave_msg.sv
// Directed bench for m_spi_slave_msg: a behavioural SPI master drives the pins, a table of
// single-byte frames plus hand-written multi-cycle sequences check the slave's outputs.
module tb_m_spi_slave_msg;

    logic       clk = 1'b0;
    logic       resetn;
    logic       sclk;
    logic       ssN;
    logic       mosi;
    logic       miso;
    logic [7:0] txData;
    logic       txReq;
    logic [7:0] rxData;
    logic       rxValid;
    logic [6:0] rxCount;
    logic       overflow;
    logic       frameDone;
    logic [5:0] raddr;
    logic [7:0] rdata;

    int total = 0;
    int bad   = 0;

    int txReqCnt     = 0;
    int rxValidCnt   = 0;
    int frameDoneCnt = 0;

    logic       txAuto  = 1'b0;
    logic [7:0] txFixed = 8'h00;
    int         txBase  = 0;

    typedef struct {
        logic [7:0] mosiByte;
        logic [7:0] txByte;
        logic [7:0] expMiso;
        logic [7:0] expRx;
        logic [6:0] expCount;
    } vec_t;

    vec_t vecs[5];

    always #5 clk = ~clk;

    // Reply source: either a fixed byte, or a running sequence 0,1,2.. advanced on each request.
    assign txData = txAuto ? 8'(txReqCnt - txBase) : txFixed;

    m_spi_slave_msg dut (
        .I_CLK        (clk),
        .I_RESETN     (resetn),
        .SCLK_SLAVE   (sclk),
        .SS_N_SLAVE   (ssN),
        .MOSI_SLAVE   (mosi),
        .MISO_SLAVE   (miso),
        .I_TX_DATA    (txData),
        .O_TX_REQ     (txReq),
        .O_RX_DATA    (rxData),
        .O_RX_VALID   (rxValid),
        .O_RX_COUNT   (rxCount),
        .O_OVERFLOW   (overflow),
        .O_FRAME_DONE (frameDone),
        .I_RADDR      (raddr),
        .O_RDATA      (rdata)
    );

    always @(negedge clk) begin
        if (txReq)     txReqCnt++;
        if (rxValid)   rxValidCnt++;
        if (frameDone) frameDoneCnt++;
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", name, actual, expected);
        end
    endtask

    task automatic waitCycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic spiBit(input logic b, output logic got);
        @(negedge clk);
        mosi = b;
        waitCycles(6);
        got  = miso;
        sclk = 1'b1;
        waitCycles(6);
        sclk = 1'b0;
    endtask

    task automatic spiByte(input logic [7:0] b, output logic [7:0] got);
        logic bit_got;
        for (int i = 7; i >= 0; i--) begin
            spiBit(b[i], bit_got);
            got[i] = bit_got;
        end
    endtask

    task automatic frameStart();
        @(negedge clk);
        ssN = 1'b0;
        waitCycles(8);
    endtask

    task automatic frameEnd();
        waitCycles(6);
        ssN = 1'b1;
        waitCycles(8);
    endtask

    task automatic readBuf(input int addr, output logic [7:0] d);
        @(negedge clk);
        raddr = 6'(addr);
        @(negedge clk);
        d = rdata;
    endtask

    task automatic applyStimulus(input vec_t v, input int idx);
        logic [7:0] got;
        logic [7:0] buf0;
        int rvBase;
        int fdBase;
        txAuto  = 1'b0;
        txFixed = v.txByte;
        rvBase  = rxValidCnt;
        fdBase  = frameDoneCnt;
        frameStart();
        spiByte(v.mosiByte, got);
        frameEnd();
        readBuf(0, buf0);
        checkOutput($sformatf("vec%0d miso byte", idx), 32'(got), 32'(v.expMiso));
        checkOutput($sformatf("vec%0d rx data", idx), 32'(rxData), 32'(v.expRx));
        checkOutput($sformatf("vec%0d rx valid count", idx), 32'(rxValidCnt - rvBase), 32'd1);
        checkOutput($sformatf("vec%0d rx count", idx), 32'(rxCount), 32'(v.expCount));
        checkOutput($sformatf("vec%0d frame done", idx), 32'(frameDoneCnt - fdBase), 32'd1);
        checkOutput($sformatf("vec%0d buffer[0]", idx), 32'(buf0), 32'(v.expRx));
    endtask

    initial begin
        logic [7:0] got;
        logic [7:0] d;
        int rvBase;
        int trBase;
        string msg;

        vecs[0] = '{8'h46, 8'hA5, 8'hA5, 8'h46, 7'd1};
        vecs[1] = '{8'h00, 8'hFF, 8'hFF, 8'h00, 7'd1};
        vecs[2] = '{8'hFF, 8'h00, 8'h00, 8'hFF, 7'd1};
        vecs[3] = '{8'h81, 8'h7E, 8'h7E, 8'h81, 7'd1};
        vecs[4] = '{8'h3C, 8'hC3, 8'hC3, 8'h3C, 7'd1};

        resetn = 1'b0;
        sclk   = 1'b0;
        ssN    = 1'b1;
        mosi   = 1'b0;
        raddr  = '0;
        waitCycles(4);
        resetn = 1'b1;
        waitCycles(4);

        $display("[TB] reset state");
        checkOutput("reset miso", 32'(miso), 32'd0);
        checkOutput("reset tx req", 32'(txReq), 32'd0);
        checkOutput("reset rx valid", 32'(rxValid), 32'd0);
        checkOutput("reset frame done", 32'(frameDone), 32'd0);
        checkOutput("reset overflow", 32'(overflow), 32'd0);
        checkOutput("reset rx data", 32'(rxData), 32'd0);
        checkOutput("reset rx count", 32'(rxCount), 32'd0);
        for (int a = 0; a < 64; a++) begin
            readBuf(a, d);
            checkOutput($sformatf("reset buffer[%0d]", a), 32'(d), 32'd0);
        end

        $display("[TB] single-byte frame table");
        for (int i = 0; i < 5; i++) begin
            applyStimulus(vecs[i], i);
        end

        $display("[TB] 11-byte frame");
        msg    = "FROM MASTER";
        txAuto = 1'b1;
        txBase = txReqCnt;
        trBase = txReqCnt;
        rvBase = rxValidCnt;
        frameStart();
        for (int i = 0; i < 11; i++) begin
            spiByte(msg[i], got);
            checkOutput($sformatf("long frame reply %0d", i), 32'(got), 32'(i));
        end
        frameEnd();
        txAuto = 1'b0;
        checkOutput("long frame tx req pulses", 32'(txReqCnt - trBase), 32'd12);
        checkOutput("long frame rx valid pulses", 32'(rxValidCnt - rvBase), 32'd11);
        checkOutput("long frame rx count", 32'(rxCount), 32'd11);
        for (int i = 0; i < 11; i++) begin
            readBuf(i, d);
            checkOutput($sformatf("long frame buffer[%0d]", i), 32'(d), 32'(msg[i]));
        end

        $display("[TB] partial second byte");
        txFixed = 8'h00;
        rvBase  = rxValidCnt;
        frameStart();
        spiByte(8'h55, got);
        spiBit(1'b0, got[0]);
        spiBit(1'b0, got[0]);
        spiBit(1'b1, got[0]);
        spiBit(1'b1, got[0]);
        spiBit(1'b0, got[0]);
        frameEnd();
        checkOutput("partial rx valid pulses", 32'(rxValidCnt - rvBase), 32'd1);
        checkOutput("partial rx count", 32'(rxCount), 32'd1);
        checkOutput("partial rx data", 32'(rxData), 32'h55);
        readBuf(0, d);
        checkOutput("partial buffer[0]", 32'(d), 32'h55);
        readBuf(1, d);
        checkOutput("partial buffer[1] keeps old", 32'(d), 32'h52);

        $display("[TB] 66-byte overflow frame");
        rvBase = rxValidCnt;
        frameStart();
        for (int i = 0; i < 66; i++) begin
            spiByte(8'(i * 3 + 1), got);
        end
        frameEnd();
        checkOutput("overflow rx valid pulses", 32'(rxValidCnt - rvBase), 32'd66);
        checkOutput("overflow rx count", 32'(rxCount), 32'd64);
        checkOutput("overflow flag", 32'(overflow), 32'd1);
        checkOutput("overflow last rx data", 32'(rxData), 32'hC4);
        readBuf(0, d);
        checkOutput("overflow buffer[0]", 32'(d), 32'h01);
        readBuf(62, d);
        checkOutput("overflow buffer[62]", 32'(d), 32'hBB);
        readBuf(63, d);
        checkOutput("overflow buffer[63]", 32'(d), 32'hBE);

        frameStart();
        checkOutput("overflow cleared at start", 32'(overflow), 32'd0);
        checkOutput("count cleared at start", 32'(rxCount), 32'd0);
        spiByte(8'h99, got);
        frameEnd();
        checkOutput("post-overflow rx count", 32'(rxCount), 32'd1);

        $display("[TB] reset mid-frame");
        frameStart();
        spiBit(1'b1, got[0]);
        spiBit(1'b0, got[0]);
        spiBit(1'b1, got[0]);
        @(negedge clk);
        resetn = 1'b0;
        #1;
        checkOutput("mid reset rx data", 32'(rxData), 32'd0);
        checkOutput("mid reset rx count", 32'(rxCount), 32'd0);
        waitCycles(3);
        resetn = 1'b1;
        rvBase = rxValidCnt;
        spiByte(8'hFF, got);
        spiByte(8'hFF, got);
        checkOutput("no rx valid before fresh frame", 32'(rxValidCnt - rvBase), 32'd0);
        frameEnd();
        rvBase = rxValidCnt;
        frameStart();
        spiByte(8'h41, got);
        frameEnd();
        checkOutput("after reset rx valid pulses", 32'(rxValidCnt - rvBase), 32'd1);
        checkOutput("after reset rx data", 32'(rxData), 32'h41);
        checkOutput("after reset rx count", 32'(rxCount), 32'd1);
        readBuf(0, d);
        checkOutput("after reset buffer[0]", 32'(d), 32'h41);
        readBuf(5, d);
        checkOutput("after reset buffer[5] cleared", 32'(d), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
